// File: rtl/uart_pkg.sv
// Shared UART constants, transmitter state encoding and parity helper.
// The receiver imports the same package so both ends agree on framing.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE  = 16;
    localparam int unsigned UART_DATA_BITS   = 8;
    localparam logic        UART_IDLE_LEVEL  = 1'b1;
    localparam logic        UART_START_LEVEL = 1'b0;
    localparam int unsigned UART_FRAME_BITS  = 1 + UART_DATA_BITS + 1 + 1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversample ticks within one bit period and flags the last tick.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_end_c
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_last;

    assign w_last      = (r_tick_cnt == TICK_W'(OVERSAMPLE - 1));
    assign o_bit_end_c = i_enable && !i_clear && w_last;

    // Wraps only through the explicit last-tick compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (i_clear) begin
            r_tick_cnt <= '0;
        end else if (i_enable) begin
            r_tick_cnt <= w_last ? '0 : r_tick_cnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop.
// One-entry holding register lets frames run back to back with no idle bit.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Tx_sample,
    input  logic                 Tx_EN,
    input  logic                 Tx_WR,
    input  logic [DATA_BITS-1:0] Tx_DATA,
    output logic                 TxD,
    output logic                 Tx_READY,
    output logic                 Tx_BUSY,
    output logic                 Tx_DONE
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    tx_state_t            r_state;
    logic                 r_txd;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_valid;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [BIT_W-1:0]     r_bit_cnt;

    tx_state_t            w_nxt_state;
    logic                 w_nxt_txd;
    logic                 w_nxt_ready;
    logic                 w_nxt_busy;
    logic                 w_nxt_done;
    logic [DATA_BITS-1:0] w_nxt_hold;
    logic                 w_nxt_hold_valid;
    logic [DATA_BITS-1:0] w_nxt_shift;
    logic                 w_nxt_parity;
    logic [BIT_W-1:0]     w_nxt_bit_cnt;
    logic                 w_load;

    logic                 w_timer_clear;
    logic                 w_timer_enable;
    logic                 w_bit_end_c;

    // Timer is held at zero whenever no frame is on the line.
    assign w_timer_clear  = !Tx_EN || (r_state == TX_IDLE);
    assign w_timer_enable = Tx_sample && (r_state != TX_IDLE);

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_timer_clear),
        .i_enable    (w_timer_enable),
        .o_bit_end_c (w_bit_end_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= TX_IDLE;
            r_txd        <= UART_IDLE_LEVEL;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_bit_cnt    <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_txd        <= w_nxt_txd;
            r_ready      <= w_nxt_ready;
            r_busy       <= w_nxt_busy;
            r_done       <= w_nxt_done;
            r_hold       <= w_nxt_hold;
            r_hold_valid <= w_nxt_hold_valid;
            r_shift      <= w_nxt_shift;
            r_parity     <= w_nxt_parity;
            r_bit_cnt    <= w_nxt_bit_cnt;
        end
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_txd        = r_txd;
        w_nxt_done       = 1'b0;
        w_nxt_hold       = r_hold;
        w_nxt_hold_valid = r_hold_valid;
        w_nxt_shift      = r_shift;
        w_nxt_parity     = r_parity;
        w_nxt_bit_cnt    = r_bit_cnt;
        w_load           = 1'b0;

        if (!Tx_EN) begin
            // Abort: the partial frame is dropped, not resumed.
            w_nxt_state      = TX_IDLE;
            w_nxt_txd        = UART_IDLE_LEVEL;
            w_nxt_hold_valid = 1'b0;
            w_nxt_bit_cnt    = '0;
        end else begin
            // READY mirrors an empty hold, so accept and drain never coincide.
            if (Tx_WR && r_ready) begin
                w_nxt_hold       = Tx_DATA;
                w_nxt_hold_valid = 1'b1;
            end

            unique case (r_state)
                TX_IDLE: begin
                    w_nxt_txd = UART_IDLE_LEVEL;
                    w_load    = r_hold_valid;
                end
                TX_START: begin
                    if (w_bit_end_c) begin
                        w_nxt_state   = TX_DATA;
                        w_nxt_txd     = r_shift[0];
                        w_nxt_bit_cnt = '0;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end_c) begin
                        w_nxt_shift = r_shift >> 1;
                        if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            w_nxt_state = TX_PARITY;
                            w_nxt_txd   = r_parity;
                        end else begin
                            w_nxt_bit_cnt = r_bit_cnt + BIT_W'(1);
                            w_nxt_txd     = r_shift[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (w_bit_end_c) begin
                        w_nxt_state = TX_STOP;
                        w_nxt_txd   = UART_IDLE_LEVEL;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end_c) begin
                        w_nxt_done = 1'b1;
                        if (r_hold_valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_nxt_state = TX_IDLE;
                        end
                    end
                end
                default: begin
                    w_nxt_state = TX_IDLE;
                    w_nxt_txd   = UART_IDLE_LEVEL;
                end
            endcase

            // Load from the hold: start bit goes out on the same edge.
            if (w_load) begin
                w_nxt_shift      = r_hold;
                w_nxt_parity     = even_parity(r_hold);
                w_nxt_hold_valid = 1'b0;
                w_nxt_bit_cnt    = '0;
                w_nxt_state      = TX_START;
                w_nxt_txd        = UART_START_LEVEL;
            end
        end

        w_nxt_ready = !w_nxt_hold_valid;
        w_nxt_busy  = (w_nxt_state != TX_IDLE);
    end

    assign TxD      = r_txd;
    assign Tx_READY = r_ready;
    assign Tx_BUSY  = r_busy;
    assign Tx_DONE  = r_done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: a tick every 4 clocks, TxD sampled
// mid-bit against hand-built frames {stop, parity, data, start}.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       reset;
    logic       Tx_sample;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD;
    logic       Tx_READY;
    logic       Tx_BUSY;
    logic       Tx_DONE;

    int n_vec = 0;
    int n_err = 0;
    int tick_total = 0;
    int done_cnt = 0;
    int phase = 0;
    logic edge_tick;

    uart_tx_framer dut (
        .clk       (clk),
        .reset     (reset),
        .Tx_sample (Tx_sample),
        .Tx_EN     (Tx_EN),
        .Tx_WR     (Tx_WR),
        .Tx_DATA   (Tx_DATA),
        .TxD       (TxD),
        .Tx_READY  (Tx_READY),
        .Tx_BUSY   (Tx_BUSY),
        .Tx_DONE   (Tx_DONE)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        edge_tick = Tx_sample;
        #1;
        if (edge_tick) tick_total++;
        if (Tx_DONE === 1'b1) done_cnt++;
        phase = (phase + 1) % 4;
        Tx_sample = (phase == 0);
    endtask

    task automatic wait_until(input int target);
        int guard = 0;
        while (tick_total < target && guard < 20000) begin
            cyc();
            guard++;
        end
    endtask

    task automatic pulse_wr(input logic [7:0] d);
        Tx_WR   = 1'b1;
        Tx_DATA = d;
        cyc();
        Tx_WR   = 1'b0;
        Tx_DATA = 8'h00;
    endtask

    // Mid-bit samples of frame bits first..last, relative to START entry t0.
    task automatic check_bits(input int t0, input logic [10:0] exp, input int first,
                              input int last, input string tag);
        for (int k = first; k <= last; k++) begin
            wait_until(t0 + 16 * k + 8);
            chk($sformatf("%s_bit%0d", tag, k), 32'(TxD), 32'(exp[k]));
            chk($sformatf("%s_busy%0d", tag, k), 32'(Tx_BUSY), 32'(1));
        end
    endtask

    task automatic idle_run(input int n, input string tag);
        int bad = 0;
        repeat (n) begin
            cyc();
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
        end
        chk(tag, 32'(bad), 32'(0));
    endtask

    initial begin
        logic [10:0] f_a5, f_01, f_3c, f_c3, f_55, f_03;
        int t0, t1, d0;

        f_a5 = {1'b1, 1'b0, 8'hA5, 1'b0};
        f_01 = {1'b1, 1'b1, 8'h01, 1'b0};
        f_3c = {1'b1, 1'b0, 8'h3C, 1'b0};
        f_c3 = {1'b1, 1'b0, 8'hC3, 1'b0};
        f_55 = {1'b1, 1'b0, 8'h55, 1'b0};
        f_03 = {1'b1, 1'b0, 8'h03, 1'b0};

        reset     = 1'b0;
        Tx_sample = 1'b0;
        Tx_EN     = 1'b1;
        Tx_WR     = 1'b0;
        Tx_DATA   = 8'h00;
        cyc();
        cyc();
        chk("rst_txd",   32'(TxD),      32'(1));
        chk("rst_ready", 32'(Tx_READY), 32'(1));
        chk("rst_busy",  32'(Tx_BUSY),  32'(0));
        chk("rst_done",  32'(Tx_DONE),  32'(0));
        reset = 1'b1;
        idle_run(10, "idle_pre");

        // Single frame 0xA5 from idle.
        d0 = done_cnt;
        pulse_wr(8'hA5);
        chk("a5_ready_drop", 32'(Tx_READY), 32'(0));
        chk("a5_txd_preload", 32'(TxD), 32'(1));
        cyc();
        chk("a5_start_txd", 32'(TxD), 32'(0));
        chk("a5_start_busy", 32'(Tx_BUSY), 32'(1));
        chk("a5_ready_back", 32'(Tx_READY), 32'(1));
        t0 = tick_total;
        check_bits(t0, f_a5, 0, 10, "a5");
        wait_until(t0 + 176);
        chk("a5_done", 32'(Tx_DONE), 32'(1));
        chk("a5_end_busy", 32'(Tx_BUSY), 32'(0));
        cyc();
        chk("a5_done_width", 32'(Tx_DONE), 32'(0));
        chk("a5_done_count", 32'(done_cnt - d0), 32'(1));
        idle_run(20, "idle_after_a5");

        // 0x01: odd payload, parity bit 1.
        pulse_wr(8'h01);
        cyc();
        t0 = tick_total;
        check_bits(t0, f_01, 0, 10, "x01");
        wait_until(t0 + 176);
        chk("x01_done", 32'(Tx_DONE), 32'(1));
        idle_run(20, "idle_after_01");

        // Back-to-back 0x3C / 0xC3; 0xFF written while hold full is dropped.
        d0 = done_cnt;
        pulse_wr(8'h3C);
        cyc();
        t0 = tick_total;
        check_bits(t0, f_3c, 0, 2, "x3c");
        chk("b2b_ready_mid", 32'(Tx_READY), 32'(1));
        pulse_wr(8'hC3);
        chk("b2b_ready_full", 32'(Tx_READY), 32'(0));
        check_bits(t0, f_3c, 3, 6, "x3c");
        chk("ff_ready_full", 32'(Tx_READY), 32'(0));
        pulse_wr(8'hFF);
        chk("ff_ignored_ready", 32'(Tx_READY), 32'(0));
        check_bits(t0, f_3c, 7, 10, "x3c");
        wait_until(t0 + 176);
        chk("b2b_done1", 32'(Tx_DONE), 32'(1));
        chk("b2b_start2_txd", 32'(TxD), 32'(0));
        chk("b2b_busy_kept", 32'(Tx_BUSY), 32'(1));
        chk("b2b_ready_drained", 32'(Tx_READY), 32'(1));
        t1 = t0 + 176;
        check_bits(t1, f_c3, 0, 10, "xc3");
        wait_until(t1 + 176);
        chk("b2b_done2", 32'(Tx_DONE), 32'(1));
        chk("b2b_end_txd", 32'(TxD), 32'(1));
        chk("b2b_end_busy", 32'(Tx_BUSY), 32'(0));
        idle_run(80, "no_ff_frame");
        chk("b2b_done_count", 32'(done_cnt - d0), 32'(2));

        // Abort 0x55 during data bit 4, writes ignored while disabled.
        d0 = done_cnt;
        pulse_wr(8'h55);
        cyc();
        t0 = tick_total;
        check_bits(t0, f_55, 0, 5, "abort55");
        Tx_EN = 1'b0;
        cyc();
        chk("abort_txd",   32'(TxD),      32'(1));
        chk("abort_busy",  32'(Tx_BUSY),  32'(0));
        chk("abort_ready", 32'(Tx_READY), 32'(1));
        chk("abort_done",  32'(Tx_DONE),  32'(0));
        pulse_wr(8'h12);
        chk("dis_wr_ready", 32'(Tx_READY), 32'(1));
        idle_run(400, "disabled_idle");
        chk("abort_no_done", 32'(done_cnt - d0), 32'(0));
        Tx_EN = 1'b1;
        cyc();
        pulse_wr(8'h55);
        cyc();
        t0 = tick_total;
        check_bits(t0, f_55, 0, 10, "resend55");
        wait_until(t0 + 176);
        chk("resend55_done", 32'(Tx_DONE), 32'(1));
        chk("resend55_count", 32'(done_cnt - d0), 32'(1));
        idle_run(20, "idle_after_55");

        // Async reset mid-parity with the clock stopped.
        pulse_wr(8'h03);
        cyc();
        t0 = tick_total;
        check_bits(t0, f_03, 0, 9, "x03");
        clk_run = 1'b0;
        #20;
        reset = 1'b0;
        #1;
        chk("async_rst_txd",   32'(TxD),      32'(1));
        chk("async_rst_ready", 32'(Tx_READY), 32'(1));
        chk("async_rst_busy",  32'(Tx_BUSY),  32'(0));
        #10;
        reset = 1'b1;
        #5;
        clk_run = 1'b1;
        idle_run(100, "idle_after_rst");
        chk("post_rst_ready", 32'(Tx_READY), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
